// File: rtl/viterbi_codec.sv
`timescale 1ns/1ps
// viterbi_codec: rate-1/2, K=4 convolutional encoder (generators 17/15 octal)
// and an independent hard-decision Viterbi decoder using register exchange.
// The two halves share only clock and reset.
module viterbi_codec #(
    parameter int TB_DEPTH = 32,
    parameter int PM_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enc_enable_i,
    input  logic       enc_d_in,
    output logic       enc_valid_o,
    output logic [1:0] enc_d_out,
    input  logic       dec_enable,
    input  logic [1:0] dec_d_in,
    output logic       dec_d_out
);

    localparam int NSTATES = 8;

    // Coded symbol {g1,g0} leaving state p={p2,p1,p0} on input bit u.
    function automatic logic [1:0] code_sym(input logic [2:0] p, input logic u);
        return {u ^ p[0] ^ p[1] ^ p[2], u ^ p[0] ^ p[2]};
    endfunction

    // Hamming distance between two 2-bit symbols, widened to metric width.
    function automatic logic [PM_W-1:0] hamming(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return PM_W'(x[0]) + PM_W'(x[1]);
    endfunction

    // Wrap-safe "a < b": metrics never drift far apart, so the sign of the
    // modular difference is the true ordering.
    function automatic logic pm_less(input logic [PM_W-1:0] a, input logic [PM_W-1:0] b);
        logic [PM_W-1:0] d;
        d = a - b;
        return d[PM_W-1];
    endfunction

    // ------------------------------------------------------------------ encoder
    logic [2:0] enc_s_q, enc_s_d;
    logic [1:0] enc_sym_q, enc_sym_d;
    logic       enc_valid_q;

    // Next encoder state and symbol; both hold while the encoder is idle.
    always_comb begin
        enc_s_d   = enc_s_q;
        enc_sym_d = enc_sym_q;
        if (enc_enable_i) begin
            enc_sym_d = code_sym(enc_s_q, enc_d_in);
            enc_s_d   = {enc_s_q[1:0], enc_d_in};
        end
    end

    // Encoder registers; valid simply tracks the enable one clock later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_s_q     <= '0;
            enc_sym_q   <= '0;
            enc_valid_q <= 1'b0;
        end else begin
            enc_s_q     <= enc_s_d;
            enc_sym_q   <= enc_sym_d;
            enc_valid_q <= enc_enable_i;
        end
    end

    assign enc_d_out   = enc_sym_q;
    assign enc_valid_o = enc_valid_q;

    // ------------------------------------------------------------------ decoder
    logic [PM_W-1:0]     pm_q   [NSTATES];
    logic [PM_W-1:0]     pm_d   [NSTATES];
    logic [TB_DEPTH-1:0] surv_q [NSTATES];
    logic [TB_DEPTH-1:0] surv_d [NSTATES];
    logic [2:0]          best_idx;
    logic                dec_out_q, dec_out_d;

    // One add-compare-select unit per destination state n; its two
    // predecessors differ only in the oldest bit, and the input bit is n0.
    generate
        for (genvar gi = 0; gi < NSTATES; gi++) begin : g_acs
            localparam logic [2:0] NS = 3'(gi);
            localparam logic [2:0] P0 = {1'b0, NS[2], NS[1]};
            localparam logic [2:0] P1 = {1'b1, NS[2], NS[1]};

            logic [PM_W-1:0] cand0, cand1, diff;
            logic            pick1;

            assign cand0 = pm_q[P0] + hamming(dec_d_in, code_sym(P0, NS[0]));
            assign cand1 = pm_q[P1] + hamming(dec_d_in, code_sym(P1, NS[0]));
            assign diff  = cand0 - cand1;
            // Strictly positive difference favours p1; ties stay with p0.
            assign pick1 = !diff[PM_W-1] && (diff != '0);

            assign pm_d[gi]   = pick1 ? cand1 : cand0;
            assign surv_d[gi] = pick1 ? {surv_q[P1][TB_DEPTH-2:0], NS[0]}
                                      : {surv_q[P0][TB_DEPTH-2:0], NS[0]};
        end
    endgenerate

    // Pick the lowest-metric state (lowest index on ties) and read its oldest survivor bit.
    always_comb begin
        best_idx = 3'd0;
        for (int i = 1; i < NSTATES; i++) begin
            if (pm_less(pm_q[i], pm_q[best_idx])) begin
                best_idx = 3'(i);
            end
        end
        dec_out_d = surv_q[best_idx][TB_DEPTH-1];
    end

    // Decoder state: everything advances together on an enabled edge and holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NSTATES; i++) begin
                pm_q[i]   <= (i == 0) ? '0 : PM_W'(16);
                surv_q[i] <= '0;
            end
            dec_out_q <= 1'b0;
        end else if (dec_enable) begin
            for (int i = 0; i < NSTATES; i++) begin
                pm_q[i]   <= pm_d[i];
                surv_q[i] <= surv_d[i];
            end
            dec_out_q <= dec_out_d;
        end
    end

    assign dec_d_out = dec_out_q;

endmodule

// File: tb/tb_viterbi_codec.sv
`timescale 1ns/1ps
// Bench for viterbi_codec: encoder output is looped back through a one-clock
// channel register (with optional sparse bit flips) into the decoder.
module tb_viterbi_codec;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enc_enable_i = 1'b0;
    logic       enc_d_in = 1'b0;
    logic       enc_valid_o;
    logic [1:0] enc_d_out;
    logic       dec_enable;
    logic [1:0] dec_d_in;
    logic       dec_d_out;

    always #5 clk = ~clk;

    viterbi_codec #(.TB_DEPTH(32), .PM_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .enc_enable_i (enc_enable_i),
        .enc_d_in     (enc_d_in),
        .enc_valid_o  (enc_valid_o),
        .enc_d_out    (enc_d_out),
        .dec_enable   (dec_enable),
        .dec_d_in     (dec_d_in),
        .dec_d_out    (dec_d_out)
    );

    // Channel: one register stage, flips one bit every 8th symbol when enabled.
    logic       dec_en_r;
    logic       dec_fired;
    logic [1:0] dec_sym_r;
    logic [1:0] err_mask;
    int         chan_idx;
    bit         err_on = 1'b0;

    always_comb begin
        err_mask = 2'b00;
        if (err_on && (chan_idx % 8 == 3))
            err_mask = (chan_idx % 16 == 3) ? 2'b01 : 2'b10;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dec_en_r  <= 1'b0;
            dec_sym_r <= 2'b00;
            dec_fired <= 1'b0;
            chan_idx  <= 0;
        end else begin
            dec_fired <= dec_en_r;
            dec_en_r  <= enc_valid_o;
            if (enc_valid_o) begin
                dec_sym_r <= enc_d_out ^ err_mask;
                chan_idx  <= chan_idx + 1;
            end
        end
    end

    assign dec_enable = dec_en_r;
    assign dec_d_in   = dec_sym_r;

    // Scoreboard state
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [1:0] enc_q[$];
    bit         dec_q[$];
    bit         bits[$];
    logic [2:0] mstate = 3'd0;
    logic [1:0] last_enc = 2'b00;
    bit         last_dec = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one encoder cycle; when enabled, queue expected symbol and decoder bit.
    task automatic push_bit(input bit b, input bit en, input bit use_exp, input logic [1:0] exp_sym);
        logic [1:0] sym;
        enc_enable_i = en;
        enc_d_in     = b;
        if (en) begin
            sym = {b ^ mstate[0] ^ mstate[1] ^ mstate[2], b ^ mstate[0] ^ mstate[2]};
            enc_q.push_back(use_exp ? exp_sym : sym);
            dec_q.push_back(bits.size() >= 32 ? bits[bits.size() - 32] : 1'b0);
            bits.push_back(b);
            mstate = {mstate[1:0], b};
        end
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse; in-flight expectations are discarded.
    task automatic do_reset();
        enc_enable_i = 1'b0;
        rst = 1'b0;
        #1;
        enc_q.delete();
        dec_q.delete();
        bits.delete();
        mstate   = 3'd0;
        last_enc = 2'b00;
        last_dec = 1'b0;
        check("rst_enc_d_out", 8'(enc_d_out), 8'd0);
        check("rst_enc_valid", 8'(enc_valid_o), 8'd0);
        check("rst_dec_d_out", 8'(dec_d_out), 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: compare on every presented output, check hold otherwise.
    always @(negedge clk) begin
        if (rst) begin
            if (enc_valid_o) begin
                if (enc_q.size() == 0) begin
                    check("enc_unexpected_valid", 8'd1, 8'd0);
                end else begin
                    last_enc = enc_q.pop_front();
                    check("enc_sym", 8'(enc_d_out), 8'(last_enc));
                end
            end else begin
                check("enc_hold", 8'(enc_d_out), 8'(last_enc));
            end
            if (dec_fired) begin
                if (dec_q.size() == 0) begin
                    check("dec_unexpected", 8'd1, 8'd0);
                end else begin
                    last_dec = dec_q.pop_front();
                    check("dec_bit", 8'(dec_d_out), 8'(last_dec));
                end
            end else begin
                check("dec_hold", 8'(dec_d_out), 8'(last_dec));
            end
        end
    end

    logic [1:0] imp_sym [5] = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b00};
    bit         imp_bit [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        int sent;
        #2;
        do_reset();

        // Impulse response, then zeros so the 1 surfaces at the decoder output.
        for (int i = 0; i < 5; i++) push_bit(imp_bit[i], 1'b1, 1'b1, imp_sym[i]);
        for (int i = 0; i < 40; i++) push_bit(1'b0, 1'b1, 1'b0, 2'b00);

        // All-zero stream, clean channel.
        do_reset();
        for (int i = 0; i < 300; i++) push_bit(1'b0, 1'b1, 1'b0, 2'b00);

        // Random stream, clean channel.
        do_reset();
        for (int i = 0; i < 256; i++) push_bit(1'($urandom_range(0, 1)), 1'b1, 1'b0, 2'b00);

        // Random stream with sparse channel errors.
        do_reset();
        err_on = 1'b1;
        for (int i = 0; i < 256; i++) push_bit(1'($urandom_range(0, 1)), 1'b1, 1'b0, 2'b00);

        // Random stream with errors and enable gaps; reset pulse at symbol 100.
        do_reset();
        sent = 0;
        while (sent < 256) begin
            if (sent == 100) begin
                do_reset();
                sent++;
            end else if ($urandom_range(0, 3) == 0) begin
                push_bit(1'b0, 1'b0, 1'b0, 2'b00);
            end else begin
                push_bit(1'($urandom_range(0, 1)), 1'b1, 1'b0, 2'b00);
                sent++;
            end
        end

        // Drain the pipeline and confirm every expected output was observed.
        enc_enable_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("enc_queue_drained", 8'(enc_q.size()), 8'd0);
        check("dec_queue_drained", 8'(dec_q.size()), 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
